// File: rtl/debounce_pkg.sv
// Shared constants, counter-width helper and edge-strobe encoding for the
// multi-channel debouncer.
package debounce_pkg;

    localparam int DEF_CHANNELS      = 32'sd4;
    localparam int DEF_SYNC_STAGES   = 32'sd2;
    localparam int DEF_STABLE_CYCLES = 32'sd1000;
    localparam int DEF_PRESCALE      = 32'sd100;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_t;

    // A counter for 0..n-1 needs clog2(n) bits, but never fewer than one.
    function automatic int cnt_width(input int n);
        if (n <= 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced bit: synchroniser chain, stability counter, accepted level
// and registered one-cycle rise/fall strobe.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic sigin,
    output logic sigout,
    output logic rise,
    output logic fall
);

    localparam int              CNT_W   = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'sd1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   samp_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   level_r;
    logic                   level_nxt_s;
    edge_t                  edge_r;
    edge_t                  edge_nxt_s;

    assign samp_s = sync_r[SYNC_STAGES-1];

    // Next-state: any agreeing sample restarts the count; the last
    // disagreeing sample of the window flips the level and fires a strobe.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        edge_nxt_s  = EDGE_NONE;
        if (samp_s == level_r) begin
            cnt_nxt_s = '0;
        end else if (tick) begin
            if (cnt_r == CNT_MAX) begin
                cnt_nxt_s   = '0;
                level_nxt_s = samp_s;
                edge_nxt_s  = samp_s ? EDGE_RISE : EDGE_FALL;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State registers, including the synchroniser shift chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r  <= '0;
            cnt_r   <= '0;
            level_r <= 1'b0;
            edge_r  <= EDGE_NONE;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], sigin};
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            edge_r  <= edge_nxt_s;
        end
    end

    assign sigout = level_r;
    assign rise   = (edge_r == EDGE_RISE);
    assign fall   = (edge_r == EDGE_FALL);

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel debouncer top: optional shared sample prescaler plus one
// debounce_channel per input. Prescaler enabled by defining DEBOUNCE_PRESCALE_EN.
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = DEF_CHANNELS,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int PRESCALE      = DEF_PRESCALE
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] sigin,
    output logic [CHANNELS-1:0] sigout,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    if ((CHANNELS < 32'sd1) || (SYNC_STAGES < 32'sd2) ||
        (STABLE_CYCLES < 32'sd1) || (PRESCALE < 32'sd1)) begin : g_param_check
        $error("multi_debouncer: parameter out of range");
    end

    logic tick_s;

`ifdef DEBOUNCE_PRESCALE_EN
    localparam int              PS_W   = cnt_width(PRESCALE);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 32'sd1);
    localparam logic [PS_W-1:0] PS_ONE = PS_W'(32'sd1);

    logic [PS_W-1:0] presc_r;

    assign tick_s = (presc_r == PS_MAX);

    // Free-running sample prescaler shared by every channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PS_ONE;
        end
    end
`else
    assign tick_s = 1'b1;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick_s),
            .sigin   (sigin[i]),
            .sigout  (sigout[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

endmodule
